// File: rtl/lru_req_arbiter_if.sv
// Requester/buffer bundle for lru_req_arbiter: per-requester req/ack/grant,
// the valid/data pair feeding the LRU buffer, busy, and a debug view of the FSM state.
interface lru_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        grant;
    logic                    buf_valid;
    logic [DATA_W-1:0]       buf_data;
    logic                    busy;
    logic [1:0]              state;      // debug: 0 idle, 1 wait, 2 done

    modport master (
        input  req, req_data,
        output ack, grant, buf_valid, buf_data, busy, state
    );

    modport slave (
        output req, req_data,
        input  ack, grant, buf_valid, buf_data, busy, state
    );
endinterface

// File: rtl/lru_req_arbiter.sv
// Round-robin sequencer sharing one LRU buffer between N_REQ requesters.
// Define LRU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer register).
module lru_req_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int GUARD_CYCLES = 12   // >= 11: buffer worst-case hit check + update walk
) (
    input logic               clk,
    input logic               rst,
    lru_req_arbiter_if.master bus
);
    // Handshake: a requester holds req (and its data) high until it sees its one-cycle
    // ack; the buffer gets one buf_valid pulse per transaction and buf_data stays
    // stable from issue until ack, since the buffer has no ready/done of its own.
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  ptr_q;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W:0]    cand;

    // Search from the pointer upward with wrap; iterating downward leaves the
    // closest requester to the pointer as the final (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_REQ)) begin
                cand = cand - (IDX_W + 1)'(N_REQ);
            end
            if (bus.req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef LRU_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [IDX_W-1:0] win_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            win_q <= '0;
        end else if (state_q == IDLE && win_found) begin
            win_q <= win_idx;
        end else if (state_q == DONE) begin
            ptr_q <= (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        end
    end
`endif

    // State register; every output is also a flop updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ack_q       <= '0;
            grant_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            grant_q     <= grant_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = WAIT;
            WAIT:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        grant_d     = grant_q;
        buf_valid_d = 1'b0;
        buf_data_d  = buf_data_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    buf_data_d  = bus.req_data[int'(win_idx) * DATA_W +: DATA_W];
                    buf_valid_d = 1'b1;
                    grant_d     = {{(N_REQ - 1){1'b0}}, 1'b1} << win_idx;
                    cnt_d       = CNT_W'(GUARD_CYCLES);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    ack_d = grant_q;
                end
            end
            DONE: begin
                ack_d   = '0;
                grant_d = '0;
            end
            default: begin
                ack_d   = '0;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.ack       = ack_q;
    assign bus.grant     = grant_q;
    assign bus.buf_valid = buf_valid_q;
    assign bus.buf_data  = buf_data_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_lru_req_arbiter.sv
// Directed bench for lru_req_arbiter: reset, single/dual service, round-robin order,
// early req drop with data change, and reset during the guard window.
module tb_lru_req_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    logic [11:0] exp_q[$];   // {expected data, expected grant}

    lru_req_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

    lru_req_arbiter #(.N_REQ(4), .DATA_W(8), .GUARD_CYCLES(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*8 +: 8] = d;
    endtask

    // Returns at the first negedge where buf_valid is high.
    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.buf_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    // Called at the buf_valid negedge; ack must appear 12 cycles later, the data
    // must still be latched, and everything must clear the cycle after.
    task automatic wait_ack(input string tag, input logic [3:0] exp_ack,
                            input logic [7:0] exp_data, input logic [3:0] drop,
                            input int early_drop);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "_valid_pulse"}, bus.buf_valid, 0);
            if (lat == early_drop) bus.req = bus.req & ~drop;
        end while (bus.ack == 4'b0 && lat < 40);
        check({tag, "_ack_lat"}, lat, 12);
        check({tag, "_ack"}, bus.ack, exp_ack);
        check({tag, "_data_hold"}, bus.buf_data, exp_data);
        bus.req = bus.req & ~drop;
        @(negedge clk);
        check({tag, "_ack_clear"}, bus.ack, 0);
        check({tag, "_grant_clear"}, bus.grant, 0);
        check({tag, "_busy_clear"}, bus.busy, 0);
    endtask

    initial begin
        logic [11:0] e;
        int          last_cyc;
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        last_cyc     = 0;
        rst          = 1'b0;
        bus.req      = 4'b0000;
        bus.req_data = '0;

        // 1: reset with all requests held, then requester 0 first
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'h40 + 8'(i));
        repeat (3) @(negedge clk);
        check("t1_rst_ack", bus.ack, 0);
        check("t1_rst_grant", bus.grant, 0);
        check("t1_rst_valid", bus.buf_valid, 0);
        check("t1_rst_busy", bus.busy, 0);
        rst = 1'b1;
        wait_valid("t1");
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_data", bus.buf_data, 8'h40);
        check("t1_busy", bus.busy, 1);
        bus.req = 4'b0001;
        wait_ack("t1", 4'b0001, 8'h40, 4'b0001, 0);

        // 2: only requester 2; later data change is ignored
        bus.req = 4'b0100;
        set_data(2, 8'hA5);
        wait_valid("t2");
        check("t2_grant", bus.grant, 4'b0100);
        check("t2_data", bus.buf_data, 8'hA5);
        set_data(2, 8'hFF);
        wait_ack("t2", 4'b0100, 8'hA5, 4'b0100, 0);

        // 3: same value from requester 1 (pointer now at 3, wraps to 1)
        bus.req = 4'b0010;
        set_data(1, 8'hA5);
        wait_valid("t3");
        check("t3_grant", bus.grant, 4'b0010);
        wait_ack("t3", 4'b0010, 8'hA5, 4'b0010, 0);

        // 4: fresh reset, all four requesting: order 0,1,2,3 at 14-cycle spacing
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_data(i, 8'h10 + 8'(i));
            exp_q.push_back({8'h10 + 8'(i), 4'b0001 << i});
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_valid("t4");
            e = exp_q.pop_front();
            check("t4_grant_order", bus.grant, e[3:0]);
            check("t4_data", bus.buf_data, e[11:4]);
            if (k > 0) check("t4_spacing", cyc - last_cyc, 14);
            last_cyc = cyc;
            wait_ack("t4", e[3:0], e[11:4], e[3:0], 0);
        end

        // 5: requester 3 drops req 3 cycles after grant and scribbles its data
        bus.req = 4'b1000;
        set_data(3, 8'h5A);
        wait_valid("t5");
        check("t5_grant", bus.grant, 4'b1000);
        set_data(3, 8'hFF);
        wait_ack("t5", 4'b1000, 8'h5A, 4'b1000, 3);

        // 6: reset during WAIT aborts with no ack; pending req[1] then served
        bus.req = 4'b0010;
        set_data(1, 8'h3C);
        wait_valid("t6");
        check("t6_grant", bus.grant, 4'b0010);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_grant", bus.grant, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_valid", bus.buf_valid, 0);
        repeat (2) @(negedge clk);
        check("t6_rst_ack", bus.ack, 0);
        rst = 1'b1;
        wait_valid("t6b");
        check("t6b_grant", bus.grant, 4'b0010);
        check("t6b_data", bus.buf_data, 8'h3C);
        wait_ack("t6b", 4'b0010, 8'h3C, 4'b0010, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lru_req_arbiter.md
Name: lru_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-entry LRU buffer (single valid/data input, no ready or done output) between N_REQ requesters.
- Selects one requester and drives a single-cycle valid pulse with stable data into the buffer.
- Holds the data stable for a fixed guard window that covers the buffer's worst-case hit-check/update walk, then pulses an ack to the served requester.
- Sits between client logic and the LRU buffer; the buffer's valid and data inputs are driven only by this block.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width; matches the buffer's data input
GUARD_CYCLES, 12, cycles the data is held after issue; must be >= 11 (buffer worst case: 5 cycles CHECKING_HIT + 5 cycles update + return to IDLE)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level; held high until that requester's ack
req_data  in  N_REQ*DATA_W  requester i's data occupies bits [i*DATA_W +: DATA_W]
ack  out  N_REQ  one-hot, one-cycle completion pulse
grant  out  N_REQ  one-hot owner of the buffer; all-zero when idle
buf_valid  out  1  to buffer valid_data; one-cycle pulse per transaction
buf_data  out  DATA_W  to buffer data; stable from issue until ack
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous): state=IDLE, ack=0, grant=0, buf_valid=0, buf_data=0, busy=0, counter=0, priority pointer=0.
- Reset mid-transaction aborts the transaction immediately: no ack is issued. The buffer resets on the same rst.
- States:
  - IDLE: at the edge where any req bit is high, select the winner by round-robin. The search starts at the pointer and wraps from N_REQ-1 to 0. At that edge: buf_data<=winner's data, buf_valid<=1, grant<=onehot(winner), counter<=GUARD_CYCLES, state<=WAIT. With no requests, stay in IDLE.
  - WAIT: buf_valid<=0 on the first WAIT edge, so it is high exactly one cycle. Counter decrements each edge. At the edge where counter==1: ack<=grant, state<=DONE.
  - DONE: one cycle with ack high. At the next edge: ack<=0, grant<=0, pointer<=(winner+1) mod N_REQ, state<=IDLE.
- Latency:
  - Sampling edge E0 → buf_valid high in cycle E0..E1.
  - Ack high in cycle E_GUARD..E_GUARD+1.
  - Earliest next sampling edge is E_GUARD+2, so peak throughput is 1 transaction per GUARD_CYCLES+2 cycles.
- Requester rules:
  - A requester must drop req no later than the edge ending its ack cycle, or it is served again.
  - If req drops mid-transaction, the transaction still completes and ack still pulses.
  - req_data changes after selection are ignored, because buf_data is latched.
- Simultaneous requests: only the winner is served. The others are not acked and compete again at the next IDLE.
- Pointer wrap: after serving N_REQ-1 the pointer becomes 0.
- Counter width is clog2(GUARD_CYCLES+1). No other arithmetic is performed.

Optional Feature:
LRU_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. The pointer register is removed and stays 0. All other timing is unchanged.
- Undefined (default): round-robin as above.

Test Plan:
1. Reset with req=4'b1111 held → ack=0, grant=0, buf_valid=0, busy=0. After release, requester 0 is served first, with buf_valid pulsed for exactly 1 cycle.
2. Only req[2]=1, data 8'hA5 → buf_data=8'hA5 from the cycle after sampling. Ack=4'b0100 rises exactly 12 cycles after sampling. The buffer's output set then contains 8'hA5 (miss path, LRU slot replaced).
3. Repeat 8'hA5 from req[1] after test 2 → hit path. Buffer contents unchanged, ack=4'b0010 after the same 12-cycle latency.
4. req=4'b1111 held continuously, each requester dropping its req after its ack → service order 0,1,2,3. Spacing between buf_valid pulses is 14 cycles. With LRU_ARB_FIXED_PRIO_EN defined, the order is also 0,1,2,3, but a re-raised req[0] preempts 3.
5. req[3] drops 3 cycles after grant → ack[3] still pulses. buf_data stays stable until DONE.
6. rst low during WAIT → grant, busy and buf_valid clear asynchronously, no ack. After release, pending req[1] is served normally.
